// File: rtl/rv6_pkg.sv
// Shared core-wide constants and types for the rv6 front end.
package rv6_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] NOP_INSN         = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, ir} buffer between instruction memory and predecode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_buf
  import rv6_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] ir_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [ILEN-1:0] head_ir_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic [1:0]   count_q, count_d;

  // Next contents: flush wins; otherwise pop shifts first, then push lands at the new tail.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i) begin
        entry_d[0] = entry_q[1];
        count_d    = count_q - 2'd1;
      end
      if (push_i) begin
        entry_d[count_d[0]] = '{pc: pc_i, ir: ir_i};
        count_d             = count_d + 2'd1;
      end
    end
  end

  // Occupancy register; only the count needs reset, payload is qualified by it.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign count_o   = count_q;
  assign head_pc_o = entry_q[0].pc;
  assign head_ir_o = entry_q[0].ir;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a 2-entry buffer.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no request outstanding; buffer full or just reset
// REQ   | imem_req high at pc_q, waiting for imem_ack
// KILL  | request outstanding but redirected; next ack is dropped
module fetch_unit
  import rv6_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ILEN-1:0] NOP      = NOP_INSN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_if,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] ir_pd,
  output logic [XLEN-1:0] pc_pd,
  output logic            stall_imem
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] last_pc_q;
  logic [1:0]      count;
  logic [1:0]      count_after_pop;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_ir;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pop             = !stall_if && (count != 2'd0);
  assign count_after_pop = count - {1'b0, pop};

  // Next state, fetch PC and push strobe; a redirect overrides any same-cycle ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect || count_after_pop != 2'd2) state_d = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          state_d = imem_ack ? ST_REQ : ST_KILL;
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + XLEN'(4);
          // this push takes the last free slot
          if (count_after_pop == 2'd1) state_d = ST_IDLE;
        end
      end
      ST_KILL: begin
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // State, fetch PC and last-consumed PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      last_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (pop) last_pc_q <= head_pc;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect),
    .push_i    (push),
    .pop_i     (pop),
    .pc_i      (pc_q),
    .ir_i      (imem_rdata),
    .count_o   (count),
    .head_pc_o (head_pc),
    .head_ir_o (head_ir)
  );

  assign imem_addr  = pc_q;
  assign stall_imem = (count == 2'd0);
  assign ir_pd      = stall_imem ? NOP       : head_ir;
  assign pc_pd      = stall_imem ? last_pc_q : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, back-pressure, redirects, empty buffer, wrap.
module tb_fetch_unit;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir_pd;
  logic [63:0] pc_pd;
  logic        stall_imem;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_if    (stall_if),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_pd       (ir_pd),
    .pc_pd       (pc_pd),
    .stall_imem  (stall_imem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall_if    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    repeat (3) tick();

    chk("rst_req",   imem_req,   0);
    chk("rst_addr",  imem_addr,  RPC);
    chk("rst_pcpd",  pc_pd,      RPC);
    chk("rst_irpd",  ir_pd,      NOPI);
    chk("rst_stall", stall_imem, 1);

    // reset release: first request at RESET_PC, held until ack
    rst_n    = 1'b1;
    stall_if = 1'b1;
    tick();
    chk("first_req",  imem_req,   1);
    chk("first_addr", imem_addr,  RPC);
    chk("first_irpd", ir_pd,      NOPI);
    tick();
    chk("hold_req",  imem_req,  1);
    chk("hold_addr", imem_addr, RPC);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick();
    chk("ack1_addr",  imem_addr,  64'h8000_0004);
    chk("ack1_req",   imem_req,   1);
    chk("ack1_irpd",  ir_pd,      32'h0010_0093);
    chk("ack1_pcpd",  pc_pd,      RPC);
    chk("ack1_stall", stall_imem, 0);

    // back-pressure: second ack fills the buffer, requests stop
    imem_rdata = 32'h0000_0113;
    tick();
    chk("full_req",  imem_req,  0);
    chk("full_addr", imem_addr, 64'h8000_0008);
    chk("full_irpd", ir_pd,     32'h0010_0093);
    imem_ack = 1'b0;
    tick();
    chk("full_hold_req", imem_req, 0);
    stall_if = 1'b0;
    tick();
    chk("pop1_req",  imem_req,  1);
    chk("pop1_addr", imem_addr, 64'h8000_0008);
    chk("pop1_irpd", ir_pd,     32'h0000_0113);
    chk("pop1_pcpd", pc_pd,     64'h8000_0004);
    tick();
    chk("pop2_stall", stall_imem, 1);
    chk("pop2_irpd",  ir_pd,      NOPI);
    chk("pop2_pcpd",  pc_pd,      64'h8000_0004);
    chk("pop2_addr",  imem_addr,  64'h8000_0008);

    // redirect while request pending -> KILL, stale ack dropped
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0103;
    tick();
    chk("kill_req",  imem_req,  0);
    chk("kill_addr", imem_addr, 64'h8000_0100);
    redirect = 1'b0;
    tick();
    chk("kill_wait_req", imem_req, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("kill_done_req",   imem_req,   1);
    chk("kill_done_addr",  imem_addr,  64'h8000_0100);
    chk("kill_done_stall", stall_imem, 1);
    chk("kill_done_irpd",  ir_pd,      NOPI);

    // same-cycle ack and redirect: buffered entry flushed, new ack discarded
    stall_if   = 1'b1;
    imem_rdata = 32'h0000_0213;
    tick();
    chk("pre_irpd", ir_pd, 32'h0000_0213);
    chk("pre_pcpd", pc_pd, 64'h8000_0100);
    imem_rdata  = 32'hCAFE_0013;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0200;
    tick();
    chk("same_req",   imem_req,   1);
    chk("same_addr",  imem_addr,  64'h8000_0200);
    chk("same_stall", stall_imem, 1);
    chk("same_irpd",  ir_pd,      NOPI);
    chk("same_pcpd",  pc_pd,      64'h8000_0004);

    // empty buffer across a 5-cycle memory latency
    redirect = 1'b0;
    imem_ack = 1'b0;
    stall_if = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lat_stall", stall_imem, 1);
      chk("lat_irpd",  ir_pd,      NOPI);
      chk("lat_addr",  imem_addr,  64'h8000_0200);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0030_0093;
    tick();
    chk("lat_ack_stall", stall_imem, 0);
    chk("lat_ack_irpd",  ir_pd,      32'h0030_0093);
    chk("lat_ack_pcpd",  pc_pd,      64'h8000_0200);
    chk("lat_ack_addr",  imem_addr,  64'h8000_0204);

    // wrap at the top of the address space
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("wrap_kill_req",  imem_req,  0);
    chk("wrap_kill_pcpd", pc_pd,     64'h8000_0200);
    redirect = 1'b0;
    imem_ack = 1'b1;
    tick();
    chk("wrap_req",  imem_req,  1);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_rdata = 32'h0040_0093;
    stall_if   = 1'b1;
    tick();
    chk("wrap_next_addr", imem_addr, 64'h0);
    chk("wrap_irpd",      ir_pd,     32'h0040_0093);
    chk("wrap_pcpd",      pc_pd,     64'hFFFF_FFFF_FFFF_FFFC);

    // reset mid-operation; the abandoned request's ack is ignored
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mid_rst_req",   imem_req,   0);
    chk("mid_rst_addr",  imem_addr,  RPC);
    chk("mid_rst_pcpd",  pc_pd,      RPC);
    chk("mid_rst_irpd",  ir_pd,      NOPI);
    chk("mid_rst_stall", stall_imem, 1);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    chk("post_rst_req",   imem_req,   1);
    chk("post_rst_addr",  imem_addr,  RPC);
    chk("post_rst_stall", stall_imem, 1);
    imem_ack = 1'b0;
    tick();
    chk("post_rst_empty", stall_imem, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP, default 32'h0000_0013, instruction presented when buffer empty.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall_if  input  1  pipeline front-end stall from control unit; high = PD does not consume.
REQ-006 SHALL have port redirect  input  1  taken branch/jump/trap; restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  64  redirect target.
REQ-008 SHALL have port imem_req  output  1  instruction memory request valid.
REQ-009 SHALL have port imem_addr  output  64  request address, word aligned.
REQ-010 SHALL have port imem_ack  input  1  one-cycle response strobe, data valid same cycle.
REQ-011 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-012 SHALL have port ir_pd  output  32  instruction to predecode stage (buffer head or NOP).
REQ-013 SHALL have port pc_pd  output  64  PC of ir_pd.
REQ-014 SHALL have port stall_imem  output  1  buffer empty; to control unit stall input.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, ir}; count 0..2.
REQ-016 SHALL keep at most one outstanding request; issue only when count + outstanding < 2.
REQ-017 SHALL run FSM IDLE -> REQ (imem_req=1) -> REQ on ack when slot remains, else IDLE; REQ -> KILL on redirect without ack; KILL -> REQ on ack.
REQ-018 SHALL hold imem_req and imem_addr stable in REQ until imem_ack.
REQ-019 SHALL, on imem_ack in REQ, push {imem_addr, imem_rdata} and advance fetch PC by 4.
REQ-020 SHALL, in KILL, discard the returning response without pushing.
REQ-021 SHALL pop the head at the edge where stall_if=0 and count>0.
REQ-022 SHALL handle push and pop in the same cycle with count unchanged.
REQ-023 SHALL drive ir_pd=NOP, pc_pd=last popped PC and stall_imem=1 combinationally while count=0.
REQ-024 SHALL, on redirect, regardless of stall_if: flush FIFO (count=0), set fetch PC to {redirect_pc[63:2], 2'b00}, discard any same-cycle ack.
REQ-025 SHALL, on redirect with no outstanding request, present imem_req at redirect target in the next cycle.
REQ-026 SHALL wrap fetch PC modulo 2^64 without flagging.

Reset
REQ-027 SHALL, while rst_n=0: state IDLE, count=0, no outstanding request, imem_req=0, imem_addr=RESET_PC, pc_pd=RESET_PC, ir_pd=NOP, stall_imem=1.
REQ-028 SHALL issue the first request at RESET_PC in the first cycle after rst_n rises.
REQ-029 SHALL abandon an outstanding request on reset mid-operation; a later ack for it is ignored.

Structure
REQ-030 SHALL take XLEN, NOP encoding and RESET_PC default from shared package rv6_pkg.
REQ-031 SHALL instantiate the 2-entry FIFO as sub-module fetch_buf; FSM and PC logic stay in fetch_unit.

Verification
REQ-032 SHALL test reset: release rst_n, ack after 1 cycle with 32'h0010_0093 -> imem_addr=0x8000_0000, next request 0x8000_0004, ir_pd=32'h0010_0093, stall_imem drops.
REQ-033 SHALL test back-pressure: stall_if=1, two acks -> count=2, imem_req low; release stall_if -> request 0x8000_0008 reissued after one pop.
REQ-034 SHALL test redirect in flight: redirect to 0x8000_0103 while request pending -> KILL, stale ack dropped, next request at 0x8000_0100.
REQ-035 SHALL test a same-cycle ack and redirect -> data discarded, count=0, request at target next cycle.
REQ-036 SHALL test empty: ack latency 5 cycles -> stall_imem=1 and ir_pd=NOP for those cycles.
REQ-037 SHALL test wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0.
